// File: rtl/v_issue_ctrl.sv
// Vector issue controller: accepts one decoded instruction, routes it to a single unit and
// either sequences LANES-wide beats (ALU/MUL) or starts a self-sequencing unit and waits for done.
module v_issue_ctrl #(
  parameter int unsigned LANES = 4,
  parameter int unsigned VL_W  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     is_vconfig,
  input  logic [3:0]               v_alu_op,
  input  logic                     is_mul,
  input  logic [2:0]               v_red_op,
  input  logic [2:0]               v_sldu_op,
  input  logic [3:0]               v_lsu_op,
  input  logic [VL_W-1:0]          vl,
  output logic [4:0]               unit_start,
  output logic [3:0]               op_code,
  output logic [VL_W-1:0]          elem_idx,
  output logic [$clog2(LANES):0]   elem_cnt,
  output logic                     last_beat,
  input  logic                     unit_stall,
  input  logic                     red_done,
  input  logic                     sldu_done,
  input  logic                     lsu_done,
  output logic                     cfg_we,
  output logic                     done,
  output logic                     illegal,
  output logic                     busy
);

  localparam int unsigned CntW = $clog2(LANES) + 1;
  localparam logic [VL_W:0] LanesW = (VL_W + 1)'(LANES);

  typedef enum logic [1:0] {
    StIdle,
    StCfg,
    StBeat,
    StWait
  } state_e;

  state_e r_state, w_state_d;

  // Unit one-hot: {lsu, sldu, red, mul, alu}
  logic [4:0]      r_unit;
  logic [3:0]      r_op;
  logic [VL_W-1:0] r_vl;
  logic [VL_W:0]   r_idx;
  logic            r_first;
  logic            r_done;
  logic            r_illegal;

  logic [VL_W:0]   w_idx_d;
  logic            w_first_d;
  logic            w_done_d;
  logic            w_illegal_d;

  logic            w_accept;
  logic            w_cfg;
  logic [4:0]      w_sel;
  logic [3:0]      w_op;
  logic            w_elemwise;
  logic [VL_W:0]   w_idx_end;
  logic [VL_W:0]   w_remain;
  logic            w_last;
  logic [CntW-1:0] w_cnt;
  logic            w_unit_done;

  assign w_accept = instr_valid && (r_state == StIdle);

  // Classification priority: vconfig > lsu > red > sldu > mul > alu
  always_comb begin
    w_cfg = 1'b0;
    w_sel = '0;
    w_op  = '0;
    if (is_vconfig) begin
      w_cfg = 1'b1;
    end else if (v_lsu_op != '0) begin
      w_sel = 5'b10000;
      w_op  = v_lsu_op;
    end else if (v_red_op != '0) begin
      w_sel = 5'b00100;
      w_op  = {1'b0, v_red_op};
    end else if (v_sldu_op != '0) begin
      w_sel = 5'b01000;
      w_op  = {1'b0, v_sldu_op};
    end else if (is_mul) begin
      w_sel = 5'b00010;
      w_op  = 4'd1;
    end else if (v_alu_op != '0) begin
      w_sel = 5'b00001;
      w_op  = v_alu_op;
    end
  end

  assign w_elemwise = w_sel[1] | w_sel[0];

  // Index math is one bit wider than vl so the end-of-vector compare cannot wrap.
  assign w_idx_end   = r_idx + LanesW;
  assign w_remain    = {1'b0, r_vl} - r_idx;
  assign w_last      = (w_idx_end >= {1'b0, r_vl});
  assign w_cnt       = (w_remain >= LanesW) ? LanesW[CntW-1:0] : w_remain[CntW-1:0];
  assign w_unit_done = |(r_unit[4:2] & {lsu_done, sldu_done, red_done});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_idx_d     = r_idx;
    w_first_d   = 1'b0;
    w_done_d    = 1'b0;
    w_illegal_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_cfg) begin
            w_state_d = StCfg;
          end else if (w_sel == '0) begin
            w_illegal_d = 1'b1;
          end else if (vl == '0) begin
            w_done_d = 1'b1;
          end else if (w_elemwise) begin
            w_state_d = StBeat;
            w_idx_d   = '0;
          end else begin
            w_state_d = StWait;
            w_first_d = 1'b1;
          end
        end
      end
      StCfg: begin
        w_state_d = StIdle;
        w_done_d  = 1'b1;
      end
      StBeat: begin
        if (!unit_stall) begin
          if (w_last) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end else begin
            w_idx_d = w_idx_end;
          end
        end
      end
      StWait: begin
        if (w_unit_done) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_unit    <= '0;
      r_op      <= '0;
      r_vl      <= '0;
      r_idx     <= '0;
      r_first   <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_unit <= w_sel;
        r_op   <= w_op;
        r_vl   <= vl;
      end
      r_idx     <= w_idx_d;
      r_first   <= w_first_d;
      r_done    <= w_done_d;
      r_illegal <= w_illegal_d;
    end
  end

  always_comb begin
    instr_ready = (r_state == StIdle);
    busy        = (r_state != StIdle);
    cfg_we      = 1'b0;
    unit_start  = '0;
    elem_idx    = '0;
    elem_cnt    = '0;
    last_beat   = 1'b0;
    op_code     = r_op;
    done        = r_done;
    illegal     = r_illegal;
    unique case (r_state)
      StCfg: cfg_we = 1'b1;
      StBeat: begin
        unit_start = r_unit;
        elem_idx   = r_idx[VL_W-1:0];
        elem_cnt   = w_cnt;
        last_beat  = w_last;
      end
      StWait: begin
        if (r_first) begin
          unit_start = r_unit;
          last_beat  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Bench for v_issue_ctrl: instruction-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_v_issue_ctrl;

  localparam int unsigned LANES = 4;
  localparam int unsigned VL_W  = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic            instr_ready;
  logic            is_vconfig;
  logic [3:0]      v_alu_op;
  logic            is_mul;
  logic [2:0]      v_red_op;
  logic [2:0]      v_sldu_op;
  logic [3:0]      v_lsu_op;
  logic [VL_W-1:0] vl;
  logic [4:0]      unit_start;
  logic [3:0]      op_code;
  logic [VL_W-1:0] elem_idx;
  logic [2:0]      elem_cnt;
  logic            last_beat;
  logic            unit_stall;
  logic            red_done;
  logic            sldu_done;
  logic            lsu_done;
  logic            cfg_we;
  logic            done;
  logic            illegal;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  v_issue_ctrl #(.LANES(LANES), .VL_W(VL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .is_vconfig (is_vconfig),
    .v_alu_op   (v_alu_op),
    .is_mul     (is_mul),
    .v_red_op   (v_red_op),
    .v_sldu_op  (v_sldu_op),
    .v_lsu_op   (v_lsu_op),
    .vl         (vl),
    .unit_start (unit_start),
    .op_code    (op_code),
    .elem_idx   (elem_idx),
    .elem_cnt   (elem_cnt),
    .last_beat  (last_beat),
    .unit_stall (unit_stall),
    .red_done   (red_done),
    .sldu_done  (sldu_done),
    .lsu_done   (lsu_done),
    .cfg_we     (cfg_we),
    .done       (done),
    .illegal    (illegal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Model: 0 idle, 1 config, 2 element beats, 3 waiting on a unit. Unit index 0..4 = alu..lsu.
  int         m_mode = 0;
  int         m_unit = 0;
  int         m_vl = 0;
  int         m_beat = 0;
  int         m_nbeats = 0;
  logic [3:0] m_op = '0;
  bit         m_first = 1'b0;
  bit         m_done = 1'b0;
  bit         m_ill = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_op = '0; m_first = 1'b0; m_done = 1'b0; m_ill = 1'b0; m_beat = 0;
    end else begin
      m_done = 1'b0;
      m_ill  = 1'b0;
      case (m_mode)
        0: if (instr_valid) begin
          m_vl   = int'(vl);
          m_unit = -1;
          m_op   = '0;
          if (is_vconfig) m_mode = 1;
          else begin
            if (v_lsu_op != 0)       begin m_unit = 4; m_op = v_lsu_op; end
            else if (v_red_op != 0)  begin m_unit = 2; m_op = {1'b0, v_red_op}; end
            else if (v_sldu_op != 0) begin m_unit = 3; m_op = {1'b0, v_sldu_op}; end
            else if (is_mul)         begin m_unit = 1; m_op = 4'd1; end
            else if (v_alu_op != 0)  begin m_unit = 0; m_op = v_alu_op; end
            if (m_unit < 0) m_ill = 1'b1;
            else if (m_vl == 0) m_done = 1'b1;
            else if (m_unit <= 1) begin
              m_mode = 2; m_beat = 0; m_nbeats = (m_vl + LANES - 1) / LANES;
            end else begin
              m_mode = 3; m_first = 1'b1;
            end
          end
        end
        1: begin m_mode = 0; m_done = 1'b1; end
        2: if (!unit_stall) begin
          m_beat++;
          if (m_beat == m_nbeats) begin m_mode = 0; m_done = 1'b1; end
        end
        3: begin
          m_first = 1'b0;
          if ((m_unit == 2 && red_done) || (m_unit == 3 && sldu_done) ||
              (m_unit == 4 && lsu_done)) begin
            m_mode = 0; m_done = 1'b1;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  function automatic logic [24:0] model_vec();
    logic [4:0] us;
    int         idx;
    int         cnt;
    logic       lb;
    us = '0; idx = 0; cnt = 0; lb = 1'b0;
    if (m_mode == 2) begin
      us  = 5'(1 << m_unit);
      idx = m_beat * LANES;
      cnt = m_vl - idx;
      if (cnt > LANES) cnt = LANES;
      lb  = (m_beat == m_nbeats - 1);
    end else if (m_mode == 3 && m_first) begin
      us = 5'(1 << m_unit);
      lb = 1'b1;
    end
    return {m_mode == 0, m_mode != 0, m_mode == 1, m_done, m_ill, us, m_op, 7'(idx), 3'(cnt), lb};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {instr_ready, busy, cfg_we, done, illegal, unit_start, op_code, elem_idx, elem_cnt,
            last_beat};
  endfunction

  function automatic logic [15:0] beat_vec();
    return {unit_start, elem_idx, elem_cnt, last_beat};
  endfunction

  always @(negedge clk) begin
    cyc++;
    check($sformatf("cycle%0d_outputs", cyc), 32'(dut_vec()), 32'(model_vec()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic cfg, input logic [3:0] alu, input logic mul,
                       input logic [2:0] red, input logic [2:0] sldu, input logic [3:0] lsu,
                       input logic [6:0] v);
    is_vconfig = cfg; v_alu_op = alu; is_mul = mul; v_red_op = red; v_sldu_op = sldu;
    v_lsu_op = lsu; vl = v; instr_valid = 1'b1;
    tick();
    // Scramble fields after accept: the DUT must work from its latched copy.
    instr_valid = 1'b0; is_vconfig = 1'b0; v_alu_op = 4'hf; is_mul = 1'b1; v_red_op = 3'd7;
    v_sldu_op = 3'd7; v_lsu_op = 4'hf; vl = 7'h7f;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0; is_vconfig = 1'b0; v_alu_op = '0; is_mul = 1'b0; v_red_op = '0;
    v_sldu_op = '0; v_lsu_op = '0; vl = '0; unit_stall = 1'b0; red_done = 1'b0;
    sldu_done = 1'b0; lsu_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(instr_ready), 32'd1);
    check("reset_outputs", 32'({unit_start, op_code, elem_idx, elem_cnt, last_beat, cfg_we, done,
                                illegal, busy}), 32'd0);
    rst = 1'b0;
    tick();

    // vadd vl=10: beats 0/4/8, counts 4/4/2, done at accept+4
    issue(1'b0, 4'd2, 1'b0, 3'd0, 3'd0, 4'd0, 7'd10);
    check("vadd_beat1", 32'(beat_vec()), 32'({5'b00001, 7'd0, 3'd4, 1'b0}));
    check("vadd_opcode", 32'(op_code), 32'd2);
    tick();
    check("vadd_beat2", 32'(beat_vec()), 32'({5'b00001, 7'd4, 3'd4, 1'b0}));
    tick();
    check("vadd_beat3", 32'(beat_vec()), 32'({5'b00001, 7'd8, 3'd2, 1'b1}));
    check("vadd_no_early_done", 32'(done), 32'd0);
    tick();
    check("vadd_done", 32'({done, instr_ready, unit_start}), 32'({1'b1, 1'b1, 5'b0}));
    tick();

    // vmul vl=8 with beat 2 stalled two cycles: done at accept+5
    issue(1'b0, 4'd0, 1'b1, 3'd0, 3'd0, 4'd0, 7'd8);
    check("vmul_beat1", 32'(beat_vec()), 32'({5'b00010, 7'd0, 3'd4, 1'b0}));
    tick();
    unit_stall = 1'b1;
    check("vmul_beat2", 32'(beat_vec()), 32'({5'b00010, 7'd4, 3'd4, 1'b1}));
    tick();
    check("vmul_stall_hold1", 32'(beat_vec()), 32'({5'b00010, 7'd4, 3'd4, 1'b1}));
    tick();
    unit_stall = 1'b0;
    check("vmul_stall_hold2", 32'(beat_vec()), 32'({5'b00010, 7'd4, 3'd4, 1'b1}));
    check("vmul_no_done", 32'(done), 32'd0);
    tick();
    check("vmul_done", 32'({done, op_code}), 32'({1'b1, 4'd1}));
    tick();

    // vle32 vl=16: single start, foreign dones ignored, back-to-back vadd in the done cycle
    issue(1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 4'd6, 7'd16);
    check("vle_start", 32'(beat_vec()), 32'({5'b10000, 7'd0, 3'd0, 1'b1}));
    tick();
    red_done = 1'b1;
    check("vle_start_once", 32'({unit_start, busy}), 32'({5'b0, 1'b1}));
    tick();
    red_done = 1'b0; sldu_done = 1'b1;
    tick();
    sldu_done = 1'b0;
    tick();
    tick();
    tick();
    lsu_done = 1'b1;
    check("vle_still_waiting", 32'({done, busy}), 32'({1'b0, 1'b1}));
    tick();
    lsu_done = 1'b0;
    check("vle_done", 32'({done, instr_ready}), 32'({1'b1, 1'b1}));
    issue(1'b0, 4'd1, 1'b0, 3'd0, 3'd0, 4'd0, 7'd4);
    check("b2b_vadd_beat", 32'(beat_vec()), 32'({5'b00001, 7'd0, 3'd4, 1'b1}));
    tick();
    check("b2b_vadd_done", 32'(done), 32'd1);
    tick();

    // vsetvli (with an lsu field set, config still wins), then an all-zero word
    issue(1'b1, 4'd0, 1'b0, 3'd0, 3'd0, 4'd2, 7'd20);
    check("cfg_we", 32'({cfg_we, busy, done, unit_start}), 32'({1'b1, 1'b1, 1'b0, 5'b0}));
    tick();
    check("cfg_done", 32'({cfg_we, busy, done}), 32'({1'b0, 1'b0, 1'b1}));
    issue(1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 4'd0, 7'd3);
    check("illegal_pulse", 32'({illegal, busy, done, unit_start}), 32'({1'b1, 1'b0, 1'b0, 5'b0}));
    tick();
    check("illegal_once", 32'(illegal), 32'd0);
    lsu_done = 1'b1;
    tick();
    lsu_done = 1'b0;
    check("idle_done_ignored", 32'({done, busy}), 32'd0);

    // Priority red > sldu > mul > alu; non-matching sldu_done ignored
    issue(1'b0, 4'd5, 1'b1, 3'd2, 3'd4, 4'd0, 7'd6);
    check("prio_red", 32'({unit_start, op_code}), 32'({5'b00100, 4'd2}));
    tick();
    sldu_done = 1'b1;
    tick();
    sldu_done = 1'b0; red_done = 1'b1;
    check("prio_wait", 32'(done), 32'd0);
    tick();
    red_done = 1'b0;
    check("prio_done", 32'(done), 32'd1);
    tick();

    // vredsum vl=0: no start, done at accept+1; vl=5 with red_done in the start cycle
    issue(1'b0, 4'd0, 1'b0, 3'd1, 3'd0, 4'd0, 7'd0);
    check("red_vl0", 32'({done, unit_start, busy}), 32'({1'b1, 5'b0, 1'b0}));
    tick();
    issue(1'b0, 4'd0, 1'b0, 3'd1, 3'd0, 4'd0, 7'd5);
    check("red_start", 32'(unit_start), 32'(5'b00100));
    red_done = 1'b1;
    tick();
    red_done = 1'b0;
    check("red_same_cycle_done", 32'({done, instr_ready}), 32'({1'b1, 1'b1}));
    tick();

    // Reset during beat 2 of vadd vl=12 aborts without done
    issue(1'b0, 4'd3, 1'b0, 3'd0, 3'd0, 4'd0, 7'd12);
    tick();
    check("rst_beat2", 32'(elem_idx), 32'd4);
    rst = 1'b1;
    #1;
    check("rst_abort", 32'({unit_start, elem_idx, elem_cnt, last_beat, done, busy, cfg_we, illegal,
                            op_code}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready_after", 32'(instr_ready), 32'd1);
    tick();
    tick();
    check("rst_no_done", 32'({done, busy}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/v_issue_ctrl.md
Name: v_issue_ctrl

Overview:
- Issue/sequencing controller between the vector decoder and the vector execution units (ALU, MUL, reduction, slide unit, LSU).
- Accepts one decoded vector instruction at a time over a valid/ready handshake and routes it to exactly one unit.
- For element-wise ops (ALU/MUL), breaks the vector length into LANES-wide beats; for self-sequencing units (RED/SLDU/LSU), issues a single start and waits for that unit's done.

Parameters:
LANES, 4, elements processed per beat by ALU/MUL (power of two, 1..16)
VL_W, 7, width of vector-length / element-index signals (max vl = 2^VL_W - 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  decoded instruction present
instr_ready  out  1  controller can accept (combinational: state==IDLE)
is_vconfig  in  1  decoded vset* instruction
v_alu_op  in  4  decoded ALU op (0 = none)
is_mul  in  1  decoded vmul
v_red_op  in  3  decoded reduction op (0 = none)
v_sldu_op  in  3  decoded slide/move op (0 = none)
v_lsu_op  in  4  decoded load/store op (0 = none)
vl  in  VL_W  current vector length, sampled at accept
unit_start  out  5  one-hot start {lsu,sldu,red,mul,alu} = bits [4:0]
op_code  out  4  latched op code of the issued unit (zero-extended)
elem_idx  out  VL_W  first element index of current beat
elem_cnt  out  $clog2(LANES)+1  active elements this beat
last_beat  out  1  current beat is final beat
unit_stall  in  1  ALU/MUL back-pressure; holds current beat
red_done  in  1  reduction unit finished
sldu_done  in  1  slide unit finished
lsu_done  in  1  LSU finished
cfg_we  out  1  one-cycle write strobe for vtype/vl CSRs
done  out  1  one-cycle pulse: instruction complete
illegal  out  1  one-cycle pulse: accepted instruction decoded to no unit
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all registered outputs 0 (unit_start, op_code, elem_idx, elem_cnt, last_beat, cfg_we, done, illegal, busy). Asserting rst mid-operation aborts the instruction; no done is produced.
- Accept: occurs when instr_valid && instr_ready. op fields and vl are latched; later changes to inputs are ignored until the next accept.
- Classification priority: is_vconfig > lsu > red > sldu > mul > alu. If none applies, pulse illegal the cycle after accept and remain in IDLE; no done.
- States:
  - IDLE: wait for accept.
  - CFG: assert cfg_we for 1 cycle, then done and go to IDLE.
  - BEAT: ALU/MUL element-wise beats.
  - WAIT: waiting for a self-sequencing unit's done.
- vl == 0 for a non-vconfig op: no unit_start; done pulses the cycle after accept.
- BEAT:
  - First beat is presented the cycle after accept, with elem_idx = 0.
  - Each cycle with unit_stall = 0, the beat is consumed and elem_idx += LANES.
  - elem_cnt = min(LANES, vl - elem_idx).
  - last_beat = (elem_idx + LANES >= vl).
  - unit_start[alu|mul] stays high for every beat, including stalled cycles. While unit_stall = 1, every beat output holds its value.
  - Consuming the final beat pulses done the next cycle and returns the FSM to IDLE.
  - Total beats = ceil(vl / LANES). Unstalled latency from accept to done = beats + 1 cycles.
- WAIT:
  - unit_start[red|sldu|lsu] pulses for exactly 1 cycle (the cycle after accept), with elem_idx = 0, elem_cnt = 0 and last_beat = 1.
  - The FSM then waits indefinitely for the matching *_done. done pulses the cycle after that *_done and the FSM returns to IDLE.
  - A *_done arriving in the same cycle as unit_start is honoured.
  - A *_done from a non-matching unit, or any *_done while IDLE, is ignored.
- Back-to-back: done and the return to IDLE occur in the same cycle, so a new instruction can be accepted in the done cycle.
- op_code holds its latched value until the next accept.
- No arithmetic overflow: elem_idx is computed in VL_W+1 bits internally; the sequence terminates on last_beat, never on wrap-around.

Test Plan:
- vadd, vl=10, LANES=4, no stall -> 3 beats (elem_idx 0/4/8, elem_cnt 4/4/2, last_beat on beat 3); unit_start=5'b00001; done at accept+4.
- vmul, vl=8, unit_stall high for 2 cycles on beat 2 -> beat 2 (elem_idx=4) held 3 cycles; unit_start=5'b00010; done at accept+5.
- vle32, vl=16, lsu_done 6 cycles after start -> unit_start=5'b10000 for 1 cycle; red_done/sldu_done pulses in between ignored; done 1 cycle after lsu_done; back-to-back vadd accepted that same cycle.
- vsetvli, then a word with all op fields 0 -> cfg_we and done pulse once; second word produces illegal pulse only, busy never asserted.
- vredsum with vl=0 -> no unit_start; done at accept+1. vredsum with vl=5 -> unit_start=5'b00100; red_done in the start cycle -> done next cycle.
- rst asserted during beat 2 of vadd vl=12 -> all outputs 0 immediately; no done; instr_ready=1 after release.
